// File: rtl/spi_buffer.sv
// spi_buffer: register/FIFO buffer between the Wishbone interface stage and
// the SPI shift engine.
//
// Bus side (four-phase handshake, one side effect per request):
//   BUF_REQ / BUF_WR / BUF_ADDR_I / BUF_DATA_I  in   access request
//   BUF_DATA_O / BUF_ACK / BUF_ERR              out  registered completion
// SPI side:
//   TX_DATA_O / TX_VALID_O / TX_READY_I         TX FIFO head, popped by engine
//   RX_DATA_I / RX_VALID_I                      RX FIFO push, no backpressure
//   SPI_EN_O / SPI_DIV_O                        CTRL[0], CTRL[15:8]
// Register map: 0x00 TXDATA, 0x04 RXDATA, 0x08 STATUS, 0x0C CTRL.
module spi_buffer #(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          WB_CLK_I,
    input  logic          WB_RST_I,
    input  logic          BUF_REQ,
    input  logic          BUF_WR,
    input  logic [7:0]    BUF_ADDR_I,
    input  logic [31:0]   BUF_DATA_I,
    output logic [31:0]   BUF_DATA_O,
    output logic          BUF_ACK,
    output logic          BUF_ERR,
    output logic [DW-1:0] TX_DATA_O,
    output logic          TX_VALID_O,
    input  logic          TX_READY_I,
    input  logic [DW-1:0] RX_DATA_I,
    input  logic          RX_VALID_I,
    output logic          SPI_EN_O,
    output logic [7:0]    SPI_DIV_O
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  en_q, en_d;
    logic [7:0]            div_q, div_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [DW-1:0]         tx_mem_q [DEPTH];
    logic [DW-1:0]         rx_mem_q [DEPTH];

    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_flush, rx_flush, ovf_clr;
    logic [31:0] status_w, ctrl_w, rx_head_w;
    logic        unused_data;

    // Bus bits that no register uses.
    assign unused_data = ^BUF_DATA_I;

    // Full/empty come from the count at the start of the cycle, so a push
    // into a full FIFO is rejected even if the other side pops this cycle.
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    always_comb begin
        status_w             = '0;
        status_w[0]          = tx_empty;
        status_w[1]          = tx_full;
        status_w[2]          = rx_empty;
        status_w[3]          = rx_full;
        status_w[4]          = ovf_q;
        status_w[8 +: CW]    = tx_cnt_q;
        status_w[16 +: CW]   = rx_cnt_q;
        ctrl_w               = '0;
        ctrl_w[0]            = en_q;
        ctrl_w[15:8]         = div_q;
        rx_head_w            = '0;
        rx_head_w[DW-1:0]    = rx_mem_q[rx_rp_q];
    end

    // Handshake FSM and register decode.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        en_d     = en_q;
        div_d    = div_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_flush = 1'b0;
        ovf_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (BUF_REQ) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    unique case (BUF_ADDR_I)
                        8'h00: begin
                            if (BUF_WR && !tx_full) tx_push = 1'b1;
                            else                    err_d   = 1'b1;
                        end
                        8'h04: begin
                            if (!BUF_WR && !rx_empty) begin
                                rx_pop  = 1'b1;
                                rdata_d = rx_head_w;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        8'h08: begin
                            if (BUF_WR) begin
                                err_d = 1'b1;
                            end else begin
                                rdata_d = status_w;
                                ovf_clr = 1'b1;
                            end
                        end
                        8'h0C: begin
                            if (BUF_WR) begin
                                en_d     = BUF_DATA_I[0];
                                tx_flush = BUF_DATA_I[1];
                                rx_flush = BUF_DATA_I[2];
                                div_d    = BUF_DATA_I[15:8];
                            end else begin
                                rdata_d = ctrl_w;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ACK: begin
                if (!BUF_REQ) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers/counts. Flush overrides any same-cycle SPI push or pop.
    always_comb begin
        tx_pop   = TX_READY_I && !tx_empty;
        rx_push  = RX_VALID_I && !rx_full && !rx_flush;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        ovf_d    = ovf_q;

        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + PTR_ONE;
            if (tx_pop)  tx_rp_d = tx_rp_q + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
            else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - CNT_ONE;
        end

        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + PTR_ONE;
            if (rx_pop)  rx_rp_d = rx_rp_q + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
            else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CNT_ONE;
        end

        // A new overflow in the same cycle as a STATUS read stays set so
        // that it is reported by the next read.
        if (ovf_clr) ovf_d = 1'b0;
        if (RX_VALID_I && rx_full && !rx_flush) ovf_d = 1'b1;
    end

    always_ff @(posedge WB_CLK_I) begin
        if (WB_RST_I) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            div_q    <= '0;
            ovf_q    <= 1'b0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Storage needs no reset: only entries inside the count are ever read.
    always_ff @(posedge WB_CLK_I) begin
        if (!WB_RST_I && tx_push) tx_mem_q[tx_wp_q] <= BUF_DATA_I[DW-1:0];
        if (!WB_RST_I && rx_push) rx_mem_q[rx_wp_q] <= RX_DATA_I;
    end

    assign BUF_ACK    = ack_q;
    assign BUF_ERR    = err_q;
    assign BUF_DATA_O = rdata_q;
    assign TX_VALID_O = !tx_empty;
    assign TX_DATA_O  = tx_empty ? '0 : tx_mem_q[tx_rp_q];
    assign SPI_EN_O   = en_q;
    assign SPI_DIV_O  = div_q;

endmodule

// File: tb/tb_spi_buffer.sv
// Self-checking bench for spi_buffer: scoreboard queues hold expected TX and
// RX words; each test task drives its scenario and compares inline.
module tb_spi_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_o;
    logic        ack_o, err_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        spi_en;
    logic [7:0]  spi_div;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_ovf = 0;

    logic [31:0] rd;
    logic        er;
    int          ac;
    logic        ar;

    always #5 clk = ~clk;

    spi_buffer #(.DW(8), .DEPTH_LOG2(4)) dut (
        .WB_CLK_I(clk), .WB_RST_I(rst),
        .BUF_REQ(req), .BUF_WR(wr), .BUF_ADDR_I(addr), .BUF_DATA_I(wdata),
        .BUF_DATA_O(rdata_o), .BUF_ACK(ack_o), .BUF_ERR(err_o),
        .TX_DATA_O(tx_data), .TX_VALID_O(tx_valid), .TX_READY_I(tx_ready),
        .RX_DATA_I(rx_data), .RX_VALID_I(rx_valid),
        .SPI_EN_O(spi_en), .SPI_DIV_O(spi_div)
    );

    function automatic logic [31:0] exp_status(int txn, int rxn, bit ovf);
        logic [31:0] s;
        s        = '0;
        s[0]     = (txn == 0);
        s[1]     = (txn == 16);
        s[2]     = (rxn == 0);
        s[3]     = (rxn == 16);
        s[4]     = ovf;
        s[12:8]  = 5'(txn);
        s[20:16] = 5'(rxn);
        return s;
    endfunction

    // One bus access; holds REQ for 'hold' cycles of ACK, then releases.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] r, output logic e,
                       output int acks, output logic ack_rel);
        bit got;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        got = 0; r = '0; e = 1'b0; acks = 0; ack_rel = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ack_o === 1'b1) got = 1;
        end
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout addr=%h: no ACK within 10 cycles", a);
            req = 1'b0;
            return;
        end
        r = rdata_o; e = err_o; acks = 1;
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            if (ack_o === 1'b1 && rdata_o === r) acks++;
        end
        req = 1'b0;
        @(negedge clk);
        ack_rel = ack_o;
    endtask

    task automatic rx_push(input logic [7:0] v);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = v;
        if (rx_q.size() < 16) rx_q.push_back(v);
        else                  m_ovf = 1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({ack_o, err_o, rdata_o, tx_valid, tx_data, spi_en, spi_div} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b err=%b data=%h txv=%b txd=%h en=%b div=%h, all required 0",
                     ack_o, err_o, rdata_o, tx_valid, tx_data, spi_en, spi_div);
        end
        rst = 1'b0;
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== 32'h5 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: data=%h err=%b, required 00000005 err=0", rd, er);
        end
        n_assert++;
        if (ar !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_release: ack=%b, required 0", ar);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 8'h08;
        @(negedge clk);
        n_assert++;
        if (ack_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_ack_before: ack=%b, required 1", ack_o);
        end
        rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if (ack_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_ack_in_reset: ack=%b, required 0", ack_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (ack_o !== 1'b1 || rdata_o !== 32'h5) begin
            n_fail++;
            $display("FAIL mid_reeval: ack=%b data=%h, required 1 / 00000005", ack_o, rdata_o);
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_single();
        tx_ready = 1'b0;
        bus(1, 8'h00, 32'h1234_56A5, 1, rd, er, ac, ar);
        tx_q.push_back(8'hA5);
        n_assert++;
        if (er !== 1'b0 || tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
            n_fail++;
            $display("FAIL tx_single: err=%b txv=%b txd=%h, required 0/1/%h", er, tx_valid, tx_data, tx_q[0]);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        void'(tx_q.pop_front());
        n_assert++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL tx_pop_single: txv=%b txd=%h, required 0/00", tx_valid, tx_data);
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) begin
            d = $urandom();
            bus(1, 8'h00, d, 1, rd, er, ac, ar);
            n_assert++;
            if (er !== (i == 16)) begin
                n_fail++;
                $display("FAIL tx_push_err[%0d]: err=%b, required %b", i, er, (i == 16));
            end
            if (tx_q.size() < 16) tx_q.push_back(d[7:0]);
        end
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(16, rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL tx_full_status: data=%h, required %h", rd, exp_status(16, rx_q.size(), m_ovf));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_assert++;
            if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
                n_fail++;
                $display("FAIL tx_drain[%0d]: txv=%b txd=%h, required 1/%h", i, tx_valid, tx_data, tx_q[0]);
            end
            void'(tx_q.pop_front());
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_assert++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL tx_drained: txv=%b, required 0", tx_valid);
        end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] e;
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(0, rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL rx_ovf_status: data=%h, required %h", rd, exp_status(0, rx_q.size(), m_ovf));
        end
        m_ovf = 0;
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(0, rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL rx_ovf_cleared: data=%h, required %h", rd, exp_status(0, rx_q.size(), m_ovf));
        end
        for (int i = 0; i < 17; i++) begin
            bus(0, 8'h04, '0, 1, rd, er, ac, ar);
            e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            n_assert++;
            if (rd !== {24'h0, e} || er !== (i == 16)) begin
                n_fail++;
                $display("FAIL rx_read[%0d]: data=%h err=%b, required %h err=%b", i, rd, er, {24'h0, e}, (i == 16));
            end
        end
    endtask

    task automatic test_ctrl();
        for (int i = 0; i < 3; i++) begin
            bus(1, 8'h00, 32'(8'h30 + i), 1, rd, er, ac, ar);
            tx_q.push_back(8'(8'h30 + i));
        end
        bus(1, 8'h0C, 32'h0000_3203, 1, rd, er, ac, ar);
        tx_q.delete();
        n_assert++;
        if (er !== 1'b0 || spi_en !== 1'b1 || spi_div !== 8'h32 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_write: err=%b en=%b div=%h txv=%b, required 0/1/32/0", er, spi_en, spi_div, tx_valid);
        end
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(0, rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL ctrl_tx_flush: status=%h, required %h", rd, exp_status(0, rx_q.size(), m_ovf));
        end
        bus(0, 8'h0C, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== 32'h0000_3201 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_read: data=%h err=%b, required 00003201 err=0", rd, er);
        end
        rx_push(8'h5A);
        rx_push(8'h5B);
        bus(1, 8'h0C, 32'hFFFF_3205, 1, rd, er, ac, ar);
        rx_q.delete();
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(0, 0, 0)) begin
            n_fail++;
            $display("FAIL ctrl_rx_flush: status=%h, required %h", rd, exp_status(0, 0, 0));
        end
        bus(0, 8'h0C, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== 32'h0000_3201) begin
            n_fail++;
            $display("FAIL ctrl_ignored_bits: data=%h, required 00003201", rd);
        end
    endtask

    task automatic test_hold();
        logic [7:0] e;
        rx_push(8'h11);
        rx_push(8'h22);
        bus(0, 8'h04, '0, 5, rd, er, ac, ar);
        e = rx_q.pop_front();
        n_assert++;
        if (rd !== {24'h0, e} || er !== 1'b0 || ac !== 5 || ar !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_read: data=%h err=%b acks=%0d rel=%b, required %h/0/5/0", rd, er, ac, ar, {24'h0, e});
        end
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(0, rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL hold_single_pop: status=%h, required %h", rd, exp_status(0, rx_q.size(), m_ovf));
        end
        bus(0, 8'h04, '0, 1, rd, er, ac, ar);
        e = rx_q.pop_front();
        n_assert++;
        if (rd !== {24'h0, e} || er !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_second: data=%h err=%b, required %h/0", rd, er, {24'h0, e});
        end
    endtask

    task automatic test_bad_addr();
        logic       ws [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] as [6] = '{8'h10, 8'h10, 8'h00, 8'h04, 8'h08, 8'h03};
        for (int i = 0; i < 6; i++) begin
            bus(ws[i], as[i], 32'hFFFF_FFFF, 1, rd, er, ac, ar);
            n_assert++;
            if (rd !== 32'h0 || er !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_access[%0d] wr=%b addr=%h: data=%h err=%b, required 0/1", i, ws[i], as[i], rd, er);
            end
        end
        bus(0, 8'h08, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== exp_status(tx_q.size(), rx_q.size(), m_ovf)) begin
            n_fail++;
            $display("FAIL bad_no_side_effect: status=%h, required %h", rd, exp_status(tx_q.size(), rx_q.size(), m_ovf));
        end
    endtask

    // RX push landing in the same cycle as a read of the empty RX FIFO.
    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 8'h04;
        rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_q.push_back(8'h77);
        n_assert++;
        if (ack_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL empty_pop_push: ack=%b err=%b data=%h, required 1/1/0", ack_o, err_o, rdata_o);
        end
        req = 1'b0;
        @(negedge clk);
        bus(0, 8'h04, '0, 1, rd, er, ac, ar);
        n_assert++;
        if (rd !== {24'h0, rx_q[0]} || er !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_push_kept: data=%h err=%b, required %h/0", rd, er, {24'h0, rx_q[0]});
        end
        void'(rx_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_tx_single();
        test_tx_full();
        test_rx_overflow();
        test_ctrl();
        test_hold();
        test_bad_addr();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_buffer.md
# spi_buffer

Register/FIFO buffer between the Wishbone interface stage and the SPI shift engine. Serves single read/write accesses issued over the `BUF_*` handshake. Decodes them into:
- a TX FIFO feeding the SPI engine,
- an RX FIFO filled by the SPI engine,
- a status register and a control register.

Each access completes with `BUF_ACK` plus `BUF_ERR`, which reports decode and FIFO errors back to the bus side.

## Interface
Parameters:
- `DW`, 8, SPI word width; bits `[DW-1:0]` of bus data are used for FIFO traffic.
- `DEPTH_LOG2`, 4, log2 of each FIFO depth (16 entries).

Ports:
- `WB_CLK_I`  in  1  single clock; all logic on rising edge.
- `WB_RST_I`  in  1  reset, synchronous, active-high.
- `BUF_REQ`  in  1  access request, held high by the bus side until `BUF_ACK` seen.
- `BUF_WR`  in  1  1 = write, 0 = read; stable while `BUF_REQ` is high.
- `BUF_ADDR_I`  in  8  register address; stable while `BUF_REQ` is high.
- `BUF_DATA_I`  in  32  write data; stable while `BUF_REQ` is high.
- `BUF_DATA_O`  out  32  read data; valid while `BUF_ACK` is high.
- `BUF_ACK`  out  1  access complete.
- `BUF_ERR`  out  1  access error; valid while `BUF_ACK` is high.
- `TX_DATA_O`  out  DW  head of TX FIFO.
- `TX_VALID_O`  out  1  TX FIFO not empty.
- `TX_READY_I`  in  1  SPI engine pops TX head when high together with `TX_VALID_O`.
- `RX_DATA_I`  in  DW  received word.
- `RX_VALID_I`  in  1  push `RX_DATA_I` this cycle; no backpressure.
- `SPI_EN_O`  out  1  `CTRL[0]`.
- `SPI_DIV_O`  out  8  `CTRL[15:8]`, SPI clock divider.

## Operation
Address map (other addresses: `BUF_ERR`=1, read data 0, no side effect):
- `0x00` TXDATA
  - Write: push `BUF_DATA_I[DW-1:0]`. If the FIFO is full, the word is dropped and `BUF_ERR`=1.
  - Read: `BUF_ERR`=1, data 0.
- `0x04` RXDATA
  - Read: pop; data is zero-extended head. If the FIFO is empty, data is 0 and `BUF_ERR`=1.
  - Write: `BUF_ERR`=1.
- `0x08` STATUS, read-only; write gives `BUF_ERR`=1. Bit layout:
  - `[0]` tx_empty, `[1]` tx_full, `[2]` rx_empty, `[3]` rx_full, `[4]` rx_overflow (sticky).
  - `[12:8]` tx_count, `[20:16]` rx_count, rest 0.
  - A STATUS read clears rx_overflow after returning it.
- `0x0C` CTRL, read/write. Fields:
  - `[0]` enable.
  - `[1]` tx_flush, `[2]` rx_flush: write-1 actions, self-clearing, read as 0.
  - `[15:8]` divider.
  - Other bits are write-ignored and read as 0.

Handshake FSM, four-phase, one side effect per request:
- IDLE: on `BUF_REQ`=1, perform the access in this cycle (decode, push/pop, register load, read data capture). Set `BUF_ACK`=1 and go to ACK.
- ACK: hold `BUF_ACK`, `BUF_DATA_O` and `BUF_ERR`. When `BUF_REQ`=0, clear `BUF_ACK` and go to IDLE.
- Reset mid-access: go to IDLE with `BUF_ACK`=0; the pending request is re-evaluated from IDLE next cycle.

FIFOs:
- Circular, with `DEPTH_LOG2`-bit pointers that wrap modulo depth and a `DEPTH_LOG2+1`-bit count.
- Full and empty are derived from the count at the start of the cycle.
- Same-cycle push and pop:
  - Allowed when the FIFO is neither empty nor full; count unchanged.
  - When full: the bus push is rejected (`BUF_ERR`=1) even if the SPI side pops in the same cycle.
  - When empty: an RX push and a bus pop in the same cycle give an error on the pop; the push is stored.
- RX push while full: word dropped, rx_overflow set.
- Flush wins over a same-cycle SPI pop or push: pointers and count go to 0 and the incoming RX word is discarded.

Reset values:
- `BUF_ACK`=0, `BUF_ERR`=0, `BUF_DATA_O`=0.
- FIFOs empty, `TX_VALID_O`=0, `TX_DATA_O`=0.
- `SPI_EN_O`=0, `SPI_DIV_O`=0, rx_overflow=0.

## Timing
- `BUF_REQ` is sampled high at edge t; `BUF_ACK`, `BUF_DATA_O` and `BUF_ERR` are registered and valid after edge t.
- `BUF_ACK` falls at the first edge at which `BUF_REQ` is sampled low. Minimum access is 2 cycles, from request to release.
- A new request can be accepted one cycle after `BUF_ACK` falls.
- TX: a word pushed at edge t makes `TX_VALID_O`=1 after t. `TX_DATA_O` is always the registered head.
- RX: a word pushed at edge t is visible in STATUS rx_count and to an RXDATA read sampled at t+1.
- CTRL writes update `SPI_EN_O` and `SPI_DIV_O` in the same edge as the access.

## Test plan
- Reset, then read STATUS → data `0x00000005`, ERR=0; `TX_VALID_O`=0, `SPI_EN_O`=0.
- Write `0x00` with `0xA5` while `TX_READY_I`=0 → ACK, ERR=0, `TX_VALID_O`=1, `TX_DATA_O`=`0xA5`. Pulse `TX_READY_I` for 1 cycle → `TX_VALID_O`=0.
- Push 16 TX words, then push a 17th → ERR=1, tx_count=16. Then pop all 16 → order preserved, pointer wraps with no corruption.
- Drive 17 `RX_VALID_I` pulses with data 0..16:
  - STATUS → rx_count=16, bit4=1; a second STATUS read shows bit4=0.
  - 16 RXDATA reads return 0..15; the 17th read → data 0, ERR=1.
- Write CTRL `0x00003203` with 3 words in TX → `SPI_EN_O`=1, `SPI_DIV_O`=`0x32`, tx_count=0; read CTRL → `0x00003201`.
- Hold `BUF_REQ` high 5 cycles on an RXDATA read with 2 words queued → exactly one pop, ACK held 5 cycles. Access to address `0x10` → ERR=1, data 0.
